and_gate: RTL and testbench
===========================

AND_GATE -- requirements
Module: and_gate

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and rst.
REQ-002 Parameter WIDTH, default 1, SHALL set the operand width; legal range 1..64.
REQ-003 Parameter CNT_W, default 16, SHALL set the hit-counter width; legal range 4..32.
REQ-004 Port clk, input, 1 bit, SHALL be the clock; all registers update on its rising edge.
REQ-005 Port rst, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-006 Port a, input, WIDTH bits, SHALL be operand A.
REQ-007 Port b, input, WIDTH bits, SHALL be operand B.
REQ-008 Port c, input, WIDTH bits, SHALL be operand C.
REQ-009 Port en, input, 1 bit, SHALL qualify the registered path and the counter.
REQ-010 Port sum, output, WIDTH bits, SHALL be the combinational bitwise AND of a, b, c.
REQ-011 Port sum_q, output, WIDTH bits, SHALL be the registered copy of sum.
REQ-012 Port sum_q_vld, output, 1 bit, SHALL flag that sum_q holds a result captured with en=1.
REQ-013 Port all_ones, output, 1 bit, SHALL be the combinational reduction-AND of sum.
REQ-014 Port hit_cnt, output, CNT_W bits, SHALL count enabled cycles with all_ones=1.
REQ-015 Port hit_sat, output, 1 bit, SHALL flag that hit_cnt is at its maximum value.

Function
REQ-016 sum SHALL equal a & b & c bit by bit, zero cycle latency, independent of clk, rst and en.
REQ-017 sum SHALL be a known 0/1 value (never X/Z) whenever a, b, c are known.
REQ-018 For WIDTH=1, sum SHALL be 1 only for a=b=c=1; all seven other input combinations give 0.
REQ-019 all_ones SHALL be 1 only when every bit of sum is 1; combinational.
REQ-020 On a rising edge with rst=0 and en=1, sum_q SHALL load sum and sum_q_vld SHALL become 1.
REQ-021 On a rising edge with rst=0 and en=0, sum_q SHALL hold its value and sum_q_vld SHALL become 0.
REQ-022 sum_q SHALL therefore lag sum by exactly one clock cycle when en=1.
REQ-023 On a rising edge with rst=0, en=1, all_ones=1 and hit_cnt below maximum, hit_cnt SHALL increment by 1.
REQ-024 hit_cnt SHALL saturate at 2^CNT_W-1 and never wrap; hit_sat SHALL equal (hit_cnt == 2^CNT_W-1), combinational from the register.
REQ-025 hit_cnt SHALL hold when en=0 or all_ones=0.
REQ-026 Input changes between clock edges SHALL affect only sum and all_ones; registers sample on edges only.

Reset
REQ-027 On a rising edge with rst=1, sum_q SHALL become 0, sum_q_vld 0, hit_cnt 0; rst overrides en.
REQ-028 hit_sat SHALL be 0 after reset.
REQ-029 sum and all_ones SHALL keep following a, b, c during reset.
REQ-030 Reset asserted mid-count SHALL clear hit_cnt on that edge; counting resumes on the first edge with rst=0.

Verification
REQ-031 WIDTH=1, step a,b,c through 000..111, 10 time units each -> sum=0 for 000..110, sum=1 for 111, never X.
REQ-032 rst=1 for 2 cycles, then rst=0 -> sum_q=0, sum_q_vld=0, hit_cnt=0, hit_sat=0.
REQ-033 a=b=c=1, en=1 -> sum=1 at once; sum_q=1 and sum_q_vld=1 after the next edge; hit_cnt=1.
REQ-034 en=1 then en=0 with a=0 -> sum_q holds 1, sum_q_vld=0, hit_cnt holds.
REQ-035 CNT_W=4, a=b=c=1, en=1 for 20 cycles -> hit_cnt stops at 15, hit_sat=1; then rst=1 for one edge -> hit_cnt=0, hit_sat=0.
REQ-036 WIDTH=8, a=8'hF0, b=8'h3C, c=8'hFF -> sum=8'h30, all_ones=0; a=b=c=8'hFF -> all_ones=1.

Source files
------------

// File: rtl/and_gate.sv
// Three-operand bitwise AND with a registered copy, a capture-valid flag and a
// saturating counter of enabled cycles on which every result bit was set.
module and_gate #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic             en,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] sum_q,
   output logic             sum_q_vld,
   output logic             all_ones,
   output logic [CNT_W-1:0] hit_cnt,
   output logic             hit_sat
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic hit_inc;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign sum[i] = a[i] & b[i] & c[i];
   end

   assign all_ones = &sum;
   assign hit_sat  = (hit_cnt == CNT_MAX);
   // Saturation is enforced by refusing the increment at the top value.
   assign hit_inc  = en & all_ones & ~hit_sat;

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q     <= '0;
         sum_q_vld <= 1'b0;
         hit_cnt   <= '0;
      end else begin
         sum_q_vld <= en;
         if (en)      sum_q   <= sum;
         if (hit_inc) hit_cnt <= hit_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_and_gate.sv
// Bench for and_gate: a 1-bit/16-bit-counter instance and an 8-bit/4-bit-counter
// instance driven side by side and compared against a behavioural model.
module tb_and_gate;

   logic        clk = 1'b0;
   logic        rst, en;
   logic [0:0]  a1, b1, c1, s1, q1;
   logic        v1, ao1, sat1;
   logic [15:0] h1;
   logic [7:0]  a8, b8, c8, s8, q8;
   logic        v8, ao8, sat8;
   logic [3:0]  h8;

   // model state
   logic [0:0]  mq1;
   logic [7:0]  mq8;
   logic        mv;
   int          mc1, mc8;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   and_gate #(.WIDTH(1), .CNT_W(16)) u1 (
      .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .en(en),
      .sum(s1), .sum_q(q1), .sum_q_vld(v1), .all_ones(ao1),
      .hit_cnt(h1), .hit_sat(sat1));

   and_gate #(.WIDTH(8), .CNT_W(4)) u8 (
      .clk(clk), .rst(rst), .a(a8), .b(b8), .c(c8), .en(en),
      .sum(s8), .sum_q(q8), .sum_q_vld(v8), .all_ones(ao8),
      .hit_cnt(h8), .hit_sat(sat8));

   // Advance the model on the rules of one rising edge, then let the edge happen.
   task automatic tick();
      int p1, p8;
      p1 = int'(a1) * int'(b1) * int'(c1);
      p8 = int'(a8 & b8 & c8);
      if (rst) begin
         mq1 = '0; mq8 = '0; mv = 1'b0; mc1 = 0; mc8 = 0;
      end else if (en) begin
         mq1 = p1[0:0];
         mq8 = p8[7:0];
         mv  = 1'b1;
         if (p1 == 1 && mc1 < 65535) mc1++;
         if (p8 == 255 && mc8 < 15) mc8++;
      end else begin
         mv = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_truth_table();
      logic [2:0] v;
      for (int i = 0; i < 8; i++) begin
         v = i[2:0];
         {a1, b1, c1} = v;
         #10;
         n_chk++;
         if (s1 !== ((i == 7) ? 1'b1 : 1'b0) || ao1 !== s1)
            $display("FAIL truth_table abc=%b sum=%b all_ones=%b want %0d", v, s1, ao1, i == 7);
         else n_pass++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1;
      a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
      a8 = 8'hFF; b8 = 8'hFF; c8 = 8'hFF;
      tick(); tick();
      n_chk++;
      if (q1 !== 1'b0 || v1 !== 1'b0 || h1 !== 16'd0 || sat1 !== 1'b0 ||
          q8 !== 8'h00 || v8 !== 1'b0 || h8 !== 4'd0 || sat8 !== 1'b0)
         $display("FAIL reset_state q1=%b v1=%b h1=%0d sat1=%b q8=%h v8=%b h8=%0d sat8=%b want all 0",
                  q1, v1, h1, sat1, q8, v8, h8, sat8);
      else n_pass++;
      n_chk++;
      if (s1 !== 1'b1 || s8 !== 8'hFF || ao8 !== 1'b1)
         $display("FAIL sum_during_reset s1=%b s8=%h ao8=%b want 1 ff 1", s1, s8, ao8);
      else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_capture();
      a8 = 8'h00; b8 = 8'h00; c8 = 8'h00;
      a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; en = 1'b1;
      #1;
      n_chk++;
      if (s1 !== 1'b1 || q1 !== 1'b0) $display("FAIL capture_comb sum=%b sum_q=%b want 1 0", s1, q1);
      else n_pass++;
      tick();
      n_chk++;
      if (q1 !== 1'b1 || v1 !== 1'b1 || h1 !== 16'd1 || h8 !== 4'd0)
         $display("FAIL capture_edge sum_q=%b vld=%b h1=%0d h8=%0d want 1 1 1 0", q1, v1, h1, h8);
      else n_pass++;
   endtask

   task automatic test_hold();
      en = 1'b0; a1 = 1'b0;
      tick();
      n_chk++;
      if (s1 !== 1'b0 || q1 !== 1'b1 || v1 !== 1'b0 || h1 !== 16'd1)
         $display("FAIL hold sum=%b sum_q=%b vld=%b h1=%0d want 0 1 0 1", s1, q1, v1, h1);
      else n_pass++;
      // Between edges only the combinational outputs may move.
      a1 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; c8 = 8'hFF; en = 1'b1;
      #2;
      n_chk++;
      if (s1 !== 1'b1 || ao8 !== 1'b1 || q1 !== 1'b1 || v1 !== 1'b0 || q8 !== 8'h00 || h8 !== 4'd0)
         $display("FAIL mid_cycle s1=%b ao8=%b q1=%b v1=%b q8=%h h8=%0d want 1 1 1 0 00 0",
                  s1, ao8, q1, v1, q8, h8);
      else n_pass++;
      en = 1'b0;
   endtask

   task automatic test_width8();
      a8 = 8'hF0; b8 = 8'h3C; c8 = 8'hFF;
      #1;
      n_chk++;
      if (s8 !== 8'h30 || ao8 !== 1'b0) $display("FAIL width8_mix sum=%h all_ones=%b want 30 0", s8, ao8);
      else n_pass++;
      a8 = 8'hFF; b8 = 8'hFF; c8 = 8'hFF;
      #1;
      n_chk++;
      if (s8 !== 8'hFF || ao8 !== 1'b1) $display("FAIL width8_ones sum=%h all_ones=%b want ff 1", s8, ao8);
      else n_pass++;
      a8 = 8'hFE;
      #1;
      n_chk++;
      if (s8 !== 8'hFE || ao8 !== 1'b0) $display("FAIL width8_one_zero sum=%h all_ones=%b want fe 0", s8, ao8);
      else n_pass++;
   endtask

   task automatic test_saturate();
      a8 = 8'hFF; b8 = 8'hFF; c8 = 8'hFF; en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         n_chk++;
         if (h8 !== mc8[3:0] || sat8 !== (mc8 == 15))
            $display("FAIL saturate cyc=%0d hit_cnt=%0d hit_sat=%b want %0d %0d", i, h8, sat8, mc8, mc8 == 15);
         else n_pass++;
      end
      n_chk++;
      if (h8 !== 4'd15 || sat8 !== 1'b1) $display("FAIL saturate_end hit_cnt=%0d hit_sat=%b want 15 1", h8, sat8);
      else n_pass++;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_chk++;
      if (h8 !== 4'd0 || sat8 !== 1'b0) $display("FAIL saturate_reset hit_cnt=%0d hit_sat=%b want 0 0", h8, sat8);
      else n_pass++;
      tick();
      n_chk++;
      if (h8 !== 4'd1) $display("FAIL resume_count hit_cnt=%0d want 1", h8);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [7:0] e8;
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 24) == 0);
         en  = ($urandom_range(0, 3) != 0);
         a1 = 1'($urandom); b1 = ($urandom_range(0, 3) != 0); c1 = ($urandom_range(0, 3) != 0);
         a8 = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom);
         b8 = ($urandom_range(0, 2) != 0) ? 8'hFF : 8'($urandom);
         c8 = ($urandom_range(0, 2) != 0) ? 8'hFF : 8'($urandom);
         #1;
         e8 = a8 & b8 & c8;
         n_chk++;
         if (s1 !== 1'(int'(a1) * int'(b1) * int'(c1)) || ao1 !== s1 || s8 !== e8 || ao8 !== (e8 == 8'hFF))
            $display("FAIL rand_comb i=%0d s1=%b ao1=%b s8=%h ao8=%b want s8=%h", i, s1, ao1, s8, ao8, e8);
         else n_pass++;
         tick();
         n_chk++;
         if (q1 !== mq1 || v1 !== mv || h1 !== 16'(mc1) || sat1 !== (mc1 == 65535) ||
             q8 !== mq8 || v8 !== mv || h8 !== 4'(mc8) || sat8 !== (mc8 == 15))
            $display("FAIL rand_reg i=%0d q1=%b v1=%b h1=%0d q8=%h v8=%b h8=%0d sat8=%b want %b %b %0d %h %b %0d %0d",
                     i, q1, v1, h1, q8, v8, h8, sat8, mq1, mv, mc1, mq8, mv, mc8, mc8 == 15);
         else n_pass++;
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0;
      a1 = '0; b1 = '0; c1 = '0; a8 = '0; b8 = '0; c8 = '0;
      mq1 = '0; mq8 = '0; mv = 1'b0; mc1 = 0; mc8 = 0;
      #1;
      test_truth_table();
      test_reset();
      test_capture();
      test_hold();
      test_width8();
      test_saturate();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
